// File: rtl/bit_serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// State encodings and the default operand width.
package bsa_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/bit_serial_adder_if.sv
// Request/result bundle between a requester and the bit-serial adder.
// master drives start/operands, slave returns status and result.
interface bit_serial_adder_if
    import bsa_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/bit_serial_adder_fa.sv
// One-bit full adder cell reused every cycle by the serial adder.
// Pure combinational datapath element.
module FA (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);
    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

// File: rtl/bit_serial_adder.sv
// Adds two WIDTH-bit operands one bit per clock, LSB first, through
// a single full-adder cell; start/done handshake around the sequence.
module bit_serial_adder
    import bsa_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    bit_serial_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_r;
    logic [WIDTH-1:0] sum_nx;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             s;
    logic             co;

    FA u_fa (
        .A    (a_reg[0]),
        .B    (b_reg[0]),
        .Cin  (carry),
        .S    (s),
        .Cout (co)
    );

    // New sum bit enters at the MSB; a 1-bit result is just S.
    if (WIDTH == 1) begin : g_w1
        assign sum_nx = s;
    end else begin : g_wn
        assign sum_nx = {s, sum_r[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = bus.start ? RUN : IDLE;
            RUN:     state_nx = (cnt == LAST) ? DONE : RUN;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            sum_r <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (state == IDLE) begin
            if (bus.start) begin
                a_reg <= bus.a;
                b_reg <= bus.b;
                sum_r <= '0;
                carry <= bus.cin;
                cnt   <= '0;
            end
        end else if (state == RUN) begin
            a_reg <= a_reg >> 1;
            b_reg <= b_reg >> 1;
            sum_r <= sum_nx;
            carry <= co;
            cnt   <= cnt + 1'b1;
        end
    end

    assign bus.busy = (state == RUN) || (state == DONE);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_r;
    assign bus.cout = carry;
endmodule
